ps2_key_controller: RTL and testbench

- Sequences the PS/2 byte stream produced by keyboard_interface into Tetrix game commands.
- Edge-detects each received scan code and tracks E0 (extended) and F0 (break) prefixes with a timeout-guarded state machine.
- Maintains held-key state, suppresses typematic repeats, and buffers commands in a small FIFO with a valid/ready handshake to the game logic.

---
 rtl/ps2_key_controller.sv | 181 ++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code sequencer: turns keyboard_interface bytes into Tetrix commands,
// tracking E0/F0 prefixes, held keys and typematic repeats, buffered in a small FIFO.
module ps2_key_controller #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 100000,
  parameter int unsigned REPEAT_EN      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [5:0] held_keys,
  output logic       overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        kc_q, kc_d;
  logic [7:0]        code_q, code_d;
  logic              evt_q, evt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [5:0]        held_q, held_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        mem_q [FIFO_DEPTH];
  logic [2:0]        mem_d [FIFO_DEPTH];

  logic [2:0]        std_cmd, ext_cmd, make_cmd, make_idx;
  logic              push, pop, full, do_push;

  // Scan-code tables: extended (E0-prefixed) and plain codes
  always_comb begin
    ext_cmd = 3'd0;
    std_cmd = 3'd0;
    case (code_q)
      8'h6B:   ext_cmd = 3'd1;
      8'h74:   ext_cmd = 3'd2;
      8'h75:   ext_cmd = 3'd3;
      8'h72:   ext_cmd = 3'd4;
      default: ext_cmd = 3'd0;
    endcase
    case (code_q)
      8'h29:   std_cmd = 3'd5;
      8'h4D:   std_cmd = 3'd6;
      default: std_cmd = 3'd0;
    endcase
  end

  // Byte-event edge detect on the nonzero level from keyboard_interface
  always_comb begin
    kc_d   = key_code;
    evt_d  = (key_code != 8'd0) && (kc_q == 8'd0);
    code_d = evt_d ? key_code : code_q;
  end

  // Prefix FSM, held-key tracking and prefix timeout
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    held_d   = held_q;
    make_cmd = 3'd0;
    make_idx = 3'd0;
    push     = 1'b0;

    if (evt_q) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (code_q == CODE_EXT)      state_d = ST_EXT;
          else if (code_q == CODE_BRK) state_d = ST_BRK;
          else                         make_cmd = std_cmd;
        end
        ST_EXT: begin
          if (code_q == CODE_BRK)      state_d = ST_EXT_BRK;
          else if (code_q != CODE_EXT) begin
            make_cmd = ext_cmd;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (std_cmd != 3'd0) held_d[3'(std_cmd - 3'd1)] = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (ext_cmd != 3'd0) held_d[3'(ext_cmd - 3'd1)] = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q >= TO_W'(PREFIX_TIMEOUT - 1)) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    // Only LEFT, RIGHT and SOFT_DROP may auto-repeat while held
    if (make_cmd != 3'd0) begin
      make_idx = 3'(make_cmd - 3'd1);
      if (!held_q[make_idx]) begin
        held_d[make_idx] = 1'b1;
        push = 1'b1;
      end else if ((REPEAT_EN != 0) &&
                   (make_cmd == 3'd1 || make_cmd == 3'd2 || make_cmd == 3'd4)) begin
        push = 1'b1;
      end
    end
  end

  // Command FIFO; a push into a full FIFO still succeeds when a pop frees a slot
  always_comb begin
    pop        = (count_q != '0) && cmd_ready;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    do_push    = push && (!full || pop);
    overflow_d = push && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = make_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      kc_q       <= '0;
      code_q     <= '0;
      evt_q      <= 1'b0;
      to_cnt_q   <= '0;
      held_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kc_d;
      code_q     <= code_d;
      evt_q      <= evt_d;
      to_cnt_q   <= to_cnt_d;
      held_q     <= held_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign cmd_valid = (count_q != '0);
  assign cmd       = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
  assign held_keys = held_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: two instances differing only in REPEAT_EN.
module tb_ps2_key_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] key_code = 8'd0;
  logic       cmd_ready = 1'b1;

  logic       cmd_valid0, cmd_valid1;
  logic [2:0] cmd0, cmd1;
  logic [5:0] held0, held1;
  logic       overflow0, overflow1;

  int errors = 0;
  int checks = 0;
  int log0[$];
  int log1[$];
  int vcyc0 = 0;
  int ovf0 = 0;

  always #5 clk = ~clk;

  ps2_key_controller #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(50), .REPEAT_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .key_code(key_code), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid0), .cmd(cmd0), .held_keys(held0), .overflow(overflow0)
  );

  ps2_key_controller #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(50), .REPEAT_EN(1)) u_dut1 (
    .clk(clk), .rst(rst), .key_code(key_code), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid1), .cmd(cmd1), .held_keys(held1), .overflow(overflow1)
  );

  // Log every command handed over to the game side
  always @(negedge clk) begin
    if (cmd_valid0) vcyc0++;
    if (overflow0) ovf0++;
    if (cmd_valid0 && cmd_ready) log0.push_back(int'(cmd0));
    if (cmd_valid1 && cmd_ready) log1.push_back(int'(cmd1));
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold = 20);
    @(posedge clk); #1 key_code = b;
    repeat (hold) @(posedge clk);
    #1 key_code = 8'd0;
    repeat (10) @(posedge clk);
  endtask

  int m0, m1, v0, o0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(cmd_valid0), 0);
    check("rst_cmd", int'(cmd0), 0);
    check("rst_held", int'(held0), 0);
    check("rst_ovf", int'(overflow0), 0);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single extended make, then its break, then a long-held plain key
    m0 = log0.size(); v0 = vcyc0;
    send(8'hE0); send(8'h6B);
    check("A_left_n", log0.size() - m0, 1);
    check("A_left_cmd", (log0.size() > m0) ? log0[m0] : -1, 1);
    check("A_left_vcyc", vcyc0 - v0, 1);
    check("A_left_held", int'(held0), 6'b000001);
    m0 = log0.size();
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("A_brk_n", log0.size() - m0, 0);
    check("A_brk_held", int'(held0), 0);
    m0 = log0.size();
    send(8'h29, 200);
    check("A_hd_n", log0.size() - m0, 1);
    check("A_hd_cmd", (log0.size() > m0) ? log0[m0] : -1, 5);
    send(8'hF0); send(8'h29);
    check("A_hd_rel", int'(held0), 0);

    // Typematic repeats: ROTATE never repeats, RIGHT repeats only with REPEAT_EN
    m0 = log0.size(); m1 = log1.size();
    repeat (3) begin send(8'hE0); send(8'h75); end
    check("B_rot_n0", log0.size() - m0, 1);
    check("B_rot_n1", log1.size() - m1, 1);
    check("B_rot_cmd1", (log1.size() > m1) ? log1[m1] : -1, 3);
    m0 = log0.size(); m1 = log1.size();
    repeat (3) begin send(8'hE0); send(8'h74); end
    check("B_right_n0", log0.size() - m0, 1);
    check("B_right_n1", log1.size() - m1, 3);
    for (int i = 0; i < 3; i++)
      check("B_right_cmd1", (log1.size() > m1 + i) ? log1[m1 + i] : -1, 2);
    check("B_held1", int'(held1), 6'b000110);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("B_rel0", int'(held0), 0);
    check("B_rel1", int'(held1), 0);

    // Fill the FIFO with ready low; fifth make overflows
    #1 cmd_ready = 1'b0;
    o0 = ovf0;
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h72);
    send(8'h29);
    check("C_ovf_pulses", ovf0 - o0, 1);
    check("C_valid", int'(cmd_valid0), 1);
    check("C_head", int'(cmd0), 1);
    check("C_held", int'(held0), 6'b011111);
    m0 = log0.size();
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("C_drain_n", log0.size() - m0, 4);
    for (int i = 0; i < 4; i++)
      check("C_drain_cmd", (log0.size() > m0 + i) ? log0[m0 + i] : -1, i + 1);
    check("C_empty", int'(cmd_valid0), 0);
    check("C_empty_cmd", int'(cmd0), 0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hF0); send(8'h29);
    check("C_rel", int'(held0), 0);

    // Prefix timeout: stale E0 and stale F0 are forgotten
    m0 = log0.size();
    send(8'hE0);
    repeat (60) @(posedge clk);
    send(8'h74);
    check("D_ext_to_n", log0.size() - m0, 0);
    check("D_ext_to_held", int'(held0), 0);
    send(8'hF0);
    repeat (60) @(posedge clk);
    send(8'h29);
    check("D_brk_to_n", log0.size() - m0, 1);
    check("D_brk_to_cmd", (log0.size() > m0) ? log0[m0] : -1, 5);
    check("D_brk_to_held", int'(held0), 6'b010000);

    // Asynchronous reset with queued commands and a pending break prefix
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    cmd_ready = 1'b0;
    send(8'h4D); send(8'h29); send(8'hF0);
    check("E_pre_valid", int'(cmd_valid0), 1);
    check("E_pre_held", int'(held0), 6'b110000);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("E_rst_valid", int'(cmd_valid0), 0);
    check("E_rst_held", int'(held0), 0);
    check("E_rst_cmd", int'(cmd0), 0);
    @(posedge clk); #1 rst = 1'b1;
    cmd_ready = 1'b1;
    m0 = log0.size();
    send(8'hE0);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    send(8'h6B);
    check("E_6b_ignored", log0.size() - m0, 0);
    send(8'h4D);
    check("E_pause_n", log0.size() - m0, 1);
    check("E_pause_cmd", (log0.size() > m0) ? log0[m0] : -1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
